ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide engine in the EX stage; consumes operands and control delivered by the ID/EX pipeline register.
- Owns the HI/LO architectural registers. Supports mult, multu, div, divu, mthi and mtlo; mfhi/mflo read OutHi/OutLo directly.
- Drives OutStall back to the front end, which freezes PC, IF/ID and ID/EX while an operation runs.

---
 rtl/ex_muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide engine owning HI/LO; one shift-add/shift-subtract step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InStart,
    input  logic [1:0]       InOp,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             InWriteHi,
    input  logic             InWriteLo,
    input  logic [WIDTH-1:0] InWriteData,
    output logic [WIDTH-1:0] OutHi,
    output logic [WIDTH-1:0] OutLo,
    output logic             OutStall,
    output logic             OutBusy,
    output logic             OutDone
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_divzero;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_sh;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [PW-1:0]    w_mul_acc;
    logic [WIDTH-1:0] w_mplier_next;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [PW-1:0]    w_div_acc;
    logic [PW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_mul_early;

    // Operand magnitudes; InOp[0] selects the signed variants
    assign w_a_neg = InOp[0] & InA[WIDTH-1];
    assign w_b_neg = InOp[0] & InB[WIDTH-1];
    assign w_a_abs = w_a_neg ? (~InA + WIDTH'(1)) : InA;
    assign w_b_abs = w_b_neg ? (~InB + WIDTH'(1)) : InB;

    // Multiply step: add the left-shifted multiplicand when the current multiplier bit is set
    assign w_mul_acc     = r_b[0] ? (r_acc + r_sh) : r_acc;
    assign w_mplier_next = r_b >> 1;

    // Restoring divide step on {remainder, quotient/dividend} held in r_acc
    assign w_rem_sh  = {r_acc[PW-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_div_acc = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_fix = r_neg_q ? (~r_acc + PW'(1)) : r_acc;
    assign w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? (~r_acc[PW-1:WIDTH] + WIDTH'(1)) : r_acc[PW-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_early = ~r_is_div & (w_mplier_next == '0);
`else
    assign w_mul_early = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and stall/busy/done decode
    always_comb begin
        w_state_next = r_state;
        OutStall     = 1'b0;
        OutBusy      = 1'b0;
        OutDone      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (InStart) begin
                    OutStall     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                OutStall = 1'b1;
                OutBusy  = 1'b1;
                if ((r_cnt == CW'(1)) || w_mul_early) begin
                    w_state_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                OutBusy      = 1'b1;
                OutDone      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, sign fixup and HI/LO writes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divzero <= 1'b0;
            r_acc     <= '0;
            r_sh      <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (InStart) begin
                        r_is_div  <= InOp[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_divzero <= InOp[1] & (InB == '0);
                        r_b       <= w_b_abs;
                        r_cnt     <= CW'(WIDTH);
                        if (InOp[1]) begin
                            // Divide keeps the raw dividend in r_sh for the divide-by-zero result
                            r_acc <= {{WIDTH{1'b0}}, w_a_abs};
                            r_sh  <= {{WIDTH{1'b0}}, InA};
                        end else begin
                            r_acc <= '0;
                            r_sh  <= {{WIDTH{1'b0}}, w_a_abs};
                        end
                    end else begin
                        if (InWriteHi) begin
                            r_hi <= InWriteData;
                        end
                        if (InWriteLo) begin
                            r_lo <= InWriteData;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_sh  <= r_sh << 1;
                        r_b   <= w_mplier_next;
                    end
                end
                S_FIXUP: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[PW-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_divzero) begin
                        r_hi <= r_sh[WIDTH-1:0];
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign OutHi = r_hi;
    assign OutLo = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed + randomized bench for ex_muldiv_unit; expected HI/LO are queued at issue and popped at completion.
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          InStart;
    logic [1:0]    InOp;
    logic [W-1:0]  InA;
    logic [W-1:0]  InB;
    logic          InWriteHi;
    logic          InWriteLo;
    logic [W-1:0]  InWriteData;
    logic [W-1:0]  OutHi;
    logic [W-1:0]  OutLo;
    logic          OutStall;
    logic          OutBusy;
    logic          OutDone;

    logic [63:0]   sb_q[$];
    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;
    int            n_pass  = 0;
    int            n_total = 0;

    always #5 Clk = ~Clk;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InStart     (InStart),
        .InOp        (InOp),
        .InA         (InA),
        .InB         (InB),
        .InWriteHi   (InWriteHi),
        .InWriteLo   (InWriteLo),
        .InWriteData (InWriteData),
        .OutHi       (OutHi),
        .OutLo       (OutLo),
        .OutStall    (OutStall),
        .OutBusy     (OutBusy),
        .OutDone     (OutDone)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference results as {HI, LO}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: begin
                p = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    // Cycles with OutStall high: start cycle + RUN cycles
    function automatic int exp_stall(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          len;
        m   = (op[0] && b[31]) ? (~b + 32'd1) : b;
        len = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) len = i + 1;
        end
        return (op[1] || !EARLY) ? int'(W) + 1 : 1 + len;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit junk);
        int          stall_n  = 0;
        int          done_n   = 0;
        int          done_cyc = -1;
        int          want;
        logic [63:0] e;
        want = exp_stall(op, b);
        sb_q.push_back({eh, el});
        @(negedge Clk);
        InStart = 1'b1;
        InOp    = op;
        InA     = a;
        InB     = b;
        if (junk) begin
            InWriteHi   = 1'b1;
            InWriteLo   = 1'b1;
            InWriteData = 32'h5A5A_A5A5;
        end
        // InStart stays high through FIXUP, as the frozen ID/EX would hold it
        for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
            #1;
            if (OutStall) stall_n++;
            if (OutDone) begin
                done_n++;
                done_cyc = cyc;
                check({tag, "_hold"}, {OutHi, OutLo}, {m_hi, m_lo});
            end
            @(negedge Clk);
        end
        InStart   = 1'b0;
        InWriteHi = 1'b0;
        InWriteLo = 1'b0;
        #1;
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(want));
        check({tag, "_stall_len"}, 64'(stall_n), 64'(want));
        check({tag, "_idle"}, {61'b0, OutBusy, OutStall, OutDone}, 64'b0);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        check({tag, "_result"}, {OutHi, OutLo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        logic [63:0] e;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dn;

        Reset       = 1'b0;
        InStart     = 1'b0;
        InOp        = 2'b00;
        InA         = '0;
        InB         = '0;
        InWriteHi   = 1'b0;
        InWriteLo   = 1'b0;
        InWriteData = '0;
        m_hi        = '0;
        m_lo        = '0;
        #2 Reset = 1'b1;
        #1;
        check("reset_outs", {OutHi, OutLo}, 64'b0);
        check("reset_ctl", {61'b0, OutStall, OutBusy, OutDone}, 64'b0);
        @(negedge Clk);
        Reset = 1'b0;

        // mthi alone, then mthi+mtlo together
        @(negedge Clk);
        InWriteHi   = 1'b1;
        InWriteData = 32'hDEAD_BEEF;
        @(negedge Clk);
        InWriteHi = 1'b0;
        #1;
        check("mthi", {OutHi, OutLo}, {32'hDEAD_BEEF, 32'h0});
        @(negedge Clk);
        InWriteHi   = 1'b1;
        InWriteLo   = 1'b1;
        InWriteData = 32'h1234_5678;
        @(negedge Clk);
        InWriteHi = 1'b0;
        InWriteLo = 1'b0;
        #1;
        check("mthi_mtlo", {OutHi, OutLo}, {32'h1234_5678, 32'h1234_5678});
        m_hi = 32'h1234_5678;
        m_lo = 32'h1234_5678;

        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_op("mult_neg",  2'b01, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        do_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("divu",      2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
        do_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        do_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op("div_zero",  2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

        // Reset in RUN cycle 10 of a mult: operation discarded
        @(negedge Clk);
        InStart = 1'b1;
        InOp    = 2'b01;
        InA     = 32'hFFFF_FFF9;
        InB     = 32'd3;
        repeat (10) @(negedge Clk);
        InStart = 1'b0;
        #1;
        check("run_stall", {62'b0, OutStall, OutBusy}, 64'b11);
        Reset = 1'b1;
        #1;
        check("rst_run_outs", {OutHi, OutLo}, 64'b0);
        check("rst_run_ctl", {61'b0, OutStall, OutBusy, OutDone}, 64'b0);
        @(negedge Clk);
        Reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        dn    = 0;
        repeat (40) begin
            @(negedge Clk);
            #1;
            if (OutDone || OutBusy) dn++;
        end
        check("rst_no_done", 64'(dn), 64'd0);

        do_op("multu_3x5", 2'b00, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);
        do_op("multu_5x1", 2'b00, 32'd5, 32'd1, 32'h0, 32'd5,  1'b0);
        do_op("mult_x0",   2'b01, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (i == 5) rb = 32'hFFFF_FFF0;
            e   = model(rop, ra, rb);
            do_op("rand", rop, ra, rb, e[63:32], e[31:0], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
